// File: rtl/data_mem_responder.sv
// Wait-stated data-memory target for the MEM stage: one outstanding load/store
// per valid/ready handshake, little-endian byte/halfword access, fault reporting.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic        byte_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        busy_q;
  logic [15:0] mem_q [DEPTH_WORDS];

  logic          acc_err;
  logic [AW-1:0] idx;
  logic [15:0]   word;

  // Word index is addr[15:1] compared unsigned, so high addresses never wrap.
  assign acc_err = ({2'b00, addr_q[15:1]} >= 17'(DEPTH_WORDS)) || (!byte_q && addr_q[0]);
  assign idx     = addr_q[AW:1];
  assign word    = mem_q[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      byte_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            write_q     <= req_write;
            byte_q      <= req_byte;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            cnt_q       <= 4'(WAIT_CYCLES);
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
          if (acc_err) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end else if (write_q) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            if (!byte_q) begin
              mem_q[idx] <= wdata_q;
            end else if (addr_q[0]) begin
              mem_q[idx][15:8] <= wdata_q[7:0];
            end else begin
              mem_q[idx][7:0] <= wdata_q[7:0];
            end
          end else begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= !byte_q ? word
                         : {8'h00, (addr_q[0] ? word[15:8] : word[7:0])};
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a wait-stated instance for the
// functional scenarios and a zero-wait instance for back-to-back traffic.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_req_valid = 1'b0, a_req_write = 1'b0, a_req_byte = 1'b0, a_rsp_ready = 1'b0;
  logic [15:0] a_req_addr = '0, a_req_wdata = '0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_busy;
  logic [15:0] a_rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_req_byte = 1'b0, b_rsp_ready = 1'b0;
  logic [15:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
  logic [15:0] b_rsp_rdata;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_byte(a_req_byte), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .busy(a_busy)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_byte(b_req_byte), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic a_issue(input logic w, input logic b, input logic [15:0] addr,
                         input logic [15:0] wd);
    @(negedge clk);
    check("a_ready_before_req", 32'(a_req_ready), 32'd1);
    a_req_valid = 1'b1;
    a_req_write = w;
    a_req_byte  = b;
    a_req_addr  = addr;
    a_req_wdata = wd;
    @(posedge clk);
    #1 a_req_valid = 1'b0;
  endtask

  // Edges counted from the accept edge inclusive until rsp_valid is seen.
  task automatic a_wait(output int lat);
    lat = 1;
    while (!a_rsp_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!a_rsp_valid) check("a_rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic a_done();
    @(negedge clk);
    a_rsp_ready = 1'b1;
    @(posedge clk);
    #1 a_rsp_ready = 1'b0;
  endtask

  task automatic xact_a(input logic w, input logic b, input logic [15:0] addr,
                        input logic [15:0] wd, output logic [15:0] rd,
                        output logic er, output int lat);
    a_issue(w, b, addr, wd);
    a_wait(lat);
    rd = a_rsp_rdata;
    er = a_rsp_err;
    a_done();
  endtask

  logic [15:0] bm [256];

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    logic        seen;
    int          t0, tprev;
    logic        w, b;
    logic [15:0] addr, wd, exp_rd;

    for (int i = 0; i < 256; i++) bm[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_req_ready", 32'(a_req_ready), 32'd1);
    check("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_a_rsp_rdata", 32'(a_rsp_rdata), 32'd0);
    check("rst_a_rsp_err",   32'(a_rsp_err),   32'd0);
    check("rst_a_busy",      32'(a_busy),      32'd0);
    check("rst_b_outputs", {27'd0, b_req_ready, b_rsp_valid, b_rsp_err, b_busy, |b_rsp_rdata},
          32'b10000);
    rst = 1'b0;

    // Halfword store and load with two wait states
    xact_a(1'b1, 1'b0, 16'h0010, 16'hBEEF, rd, er, lat);
    check("st_hw_lat", 32'(lat), 32'd4);
    check("st_hw_rdata", 32'(rd), 32'd0);
    check("st_hw_err", 32'(er), 32'd0);
    xact_a(1'b0, 1'b0, 16'h0010, 16'h0000, rd, er, lat);
    check("ld_hw_lat", 32'(lat), 32'd4);
    check("ld_hw_rdata", 32'(rd), 32'hBEEF);
    check("ld_hw_err", 32'(er), 32'd0);

    // Byte lane write and reads
    xact_a(1'b1, 1'b1, 16'h0011, 16'hFF5A, rd, er, lat);
    check("st_b_err", 32'(er), 32'd0);
    xact_a(1'b0, 1'b1, 16'h0011, 16'h0000, rd, er, lat);
    check("ld_b_odd", 32'(rd), 32'h005A);
    xact_a(1'b0, 1'b1, 16'h0010, 16'h0000, rd, er, lat);
    check("ld_b_even", 32'(rd), 32'h00EF);
    xact_a(1'b0, 1'b0, 16'h0010, 16'h0000, rd, er, lat);
    check("ld_hw_merged", 32'(rd), 32'h5AEF);

    // Faults leave storage untouched
    xact_a(1'b1, 1'b0, 16'h0000, 16'hC3A5, rd, er, lat);
    xact_a(1'b0, 1'b0, 16'h0003, 16'h0000, rd, er, lat);
    check("misalign_ld", {15'd0, er, rd}, {15'd0, 1'b1, 16'h0000});
    xact_a(1'b1, 1'b0, 16'h0200, 16'h7777, rd, er, lat);
    check("range_st", {15'd0, er, rd}, {15'd0, 1'b1, 16'h0000});
    xact_a(1'b1, 1'b0, 16'h0001, 16'hFFFF, rd, er, lat);
    check("misalign_st", {15'd0, er, rd}, {15'd0, 1'b1, 16'h0000});
    xact_a(1'b0, 1'b1, 16'hFFFF, 16'h0000, rd, er, lat);
    check("range_ld_b_top", {15'd0, er, rd}, {15'd0, 1'b1, 16'h0000});
    xact_a(1'b0, 1'b0, 16'h0000, 16'h0000, rd, er, lat);
    check("ld_after_faults", {15'd0, er, rd}, {15'd0, 1'b0, 16'hC3A5});
    xact_a(1'b0, 1'b1, 16'h01FF, 16'h0000, rd, er, lat);
    check("ld_b_last_byte", {15'd0, er, rd}, {15'd0, 1'b0, 16'h0000});

    // Response held by back-pressure while new requests are offered
    a_issue(1'b0, 1'b0, 16'h0010, 16'h0000);
    a_wait(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_req_valid = 1'b1;
      a_req_write = 1'b1;
      a_req_addr  = 16'h0010;
      a_req_wdata = 16'h1111;
      check("hold_rsp_valid", 32'(a_rsp_valid), 32'd1);
      check("hold_rsp_rdata", 32'(a_rsp_rdata), 32'h5AEF);
      check("hold_rsp_err",   32'(a_rsp_err),   32'd0);
      check("hold_req_ready", 32'(a_req_ready), 32'd0);
    end
    @(negedge clk);
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(posedge clk);
    #1 a_rsp_ready = 1'b0;
    check("release_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("release_req_ready", 32'(a_req_ready), 32'd1);
    check("release_busy",      32'(a_busy),      32'd0);
    @(posedge clk);
    #1 check("no_stray_accept", 32'(a_busy), 32'd0);
    xact_a(1'b0, 1'b0, 16'h0010, 16'h0000, rd, er, lat);
    check("hold_no_write", 32'(rd), 32'h5AEF);

    // Reset in WAIT drops the store
    a_issue(1'b1, 1'b0, 16'h0020, 16'h1234);
    check("wait_busy", 32'(a_busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy",      32'(a_busy),      32'd0);
    check("rst_mid_req_ready", 32'(a_req_ready), 32'd1);
    check("rst_mid_rsp_valid", 32'(a_rsp_valid), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 seen = seen | a_rsp_valid;
    end
    check("rst_no_response", 32'(seen), 32'd0);
    xact_a(1'b0, 1'b0, 16'h0020, 16'h0000, rd, er, lat);
    check("rst_store_dropped", {15'd0, er, rd}, {15'd0, 1'b0, 16'h0000});

    // Zero-wait instance: back-to-back traffic against a reference model
    b_rsp_ready = 1'b1;
    tprev = 0;
    for (int k = 0; k < 100; k++) begin
      w    = 1'($urandom_range(0, 1));
      b    = 1'($urandom_range(0, 1));
      addr = 16'($urandom_range(0, 63));
      if (!b) addr[0] = 1'b0;
      wd   = 16'($urandom);
      if (w) begin
        exp_rd = 16'h0000;
        if (!b)          bm[addr[15:1]]       = wd;
        else if (addr[0]) bm[addr[15:1]][15:8] = wd[7:0];
        else              bm[addr[15:1]][7:0]  = wd[7:0];
      end else if (!b) begin
        exp_rd = bm[addr[15:1]];
      end else begin
        exp_rd = {8'h00, (addr[0] ? bm[addr[15:1]][15:8] : bm[addr[15:1]][7:0])};
      end
      @(negedge clk);
      check("b_ready", 32'(b_req_ready), 32'd1);
      b_req_valid = 1'b1;
      b_req_write = w;
      b_req_byte  = b;
      b_req_addr  = addr;
      b_req_wdata = wd;
      @(posedge clk);
      #1 b_req_valid = 1'b0;
      t0 = cyc;
      if (k > 0) check("b_period", 32'(t0 - tprev), 32'd3);
      tprev = t0;
      @(posedge clk);
      #1;
      check("b_rsp", {14'd0, b_rsp_valid, b_rsp_err, b_rsp_rdata},
            {14'd0, 1'b1, 1'b0, exp_rd});
      @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
